// File: rtl/if_id_queue_pkg.sv
// if_id_queue shared constants: sysconfig values and payload field layout.
// Payload = {trap, bpu, inst} packed LSB-first at the offsets below.
package if_id_queue_pkg;

  // sysconfig
  localparam int          INST_LEN      = 32;
  localparam logic [31:0] INST_NOP      = 32'h0000_0013;
  localparam logic [31:0] PC_RESET_ADDR = 32'h8000_0000;
  localparam int          TRAP_LEN      = 8;
  localparam int          HISLEN        = 16;

  // payload layout
  localparam int INST_OFF = 0;
  localparam int BPU_OFF  = INST_OFF + INST_LEN;
  localparam int BPU_LEN  = 1 + 32 + HISLEN;
  localparam int TRAP_OFF = BPU_OFF + BPU_LEN;
  localparam int USED_W   = TRAP_OFF + TRAP_LEN;

  function automatic logic [INST_LEN-1:0] payload_inst(
    input logic [127:0] p
  );
    return p[INST_OFF +: INST_LEN];
  endfunction

endpackage

// File: rtl/if_id_queue_mem.sv
// if_id_queue_mem: DEPTH x W storage, synchronous write, async read.
// Ports: clk, we/waddr/wdata write side, raddr/rdata read side.
module if_id_queue_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 160,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: IF->ID circular FIFO with flush and reset-guard PC drop.
// Ports: clk, rst (async low), flush_i, in_* push side, out_* pop side, count_o.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int                     ADDR_W      = 32,
  parameter int                     PAYLOAD_W   = 128,
  parameter int                     DEPTH       = 4,
  parameter bit                     DROP_EN     = 1'b1,
  parameter logic [ADDR_W-1:0]      DROP_ADDR   =
    ADDR_W'(PC_RESET_ADDR - 32'd4),
  parameter logic [PAYLOAD_W-1:0]   NOP_PAYLOAD =
    PAYLOAD_W'(INST_NOP) << INST_OFF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [ADDR_W-1:0]            in_pc_i,
  input  logic [PAYLOAD_W-1:0]         in_payload_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [ADDR_W-1:0]            out_pc_o,
  output logic [PAYLOAD_W-1:0]         out_payload_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int ENT_W = ADDR_W + PAYLOAD_W;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic             drop;
  logic             wr_en;
  logic [ENT_W-1:0] rd_ent;

  assign in_ready_o  = (count != CNT_W'(DEPTH));
  assign out_valid_o = (count != '0) && !flush_i;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  // dropped PCs still handshake but never land in storage
  assign drop        = DROP_EN && (in_pc_i == DROP_ADDR);
  assign wr_en       = push && !drop && !flush_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(wr_en) - CNT_W'(pop);
    end
  end

  if_id_queue_mem #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata ({in_pc_i, in_payload_i}),
    .raddr (rd_ptr),
    .rdata (rd_ent)
  );

  assign out_pc_o      = out_valid_o ? rd_ent[ENT_W-1 -: ADDR_W] : '0;
  assign out_payload_o = out_valid_o ? rd_ent[PAYLOAD_W-1:0]
                                     : NOP_PAYLOAD;
  assign count_o       = count;

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed self-checking bench for if_id_queue.
// Default parameters (DEPTH=4, DROP_ADDR=0x7FFFFFFC).
module tb_if_id_queue;
  import if_id_queue_pkg::*;

  localparam logic [127:0] NOP = 128'(INST_NOP);
  localparam logic [31:0]  DRP = 32'h7FFF_FFFC;

  logic         clk;
  logic         rst;
  logic         flush_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [31:0]  in_pc_i;
  logic [127:0] in_payload_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [31:0]  out_pc_o;
  logic [127:0] out_payload_o;
  logic [2:0]   count_o;

  int checks;
  int failures;

  if_id_queue dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_pc_i       (in_pc_i),
    .in_payload_i  (in_payload_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_pc_o      (out_pc_o),
    .out_payload_o (out_payload_o),
    .count_o       (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] pay(input logic [31:0] pc);
    return {pc, ~pc, pc ^ 32'hA5A5_A5A5, 32'h0000_1234};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc,
                       input logic rdy);
    in_valid_i   = v;
    in_pc_i      = pc;
    in_payload_i = pay(pc);
    out_ready_i  = rdy;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rdy"}, 128'(in_ready_o), 128'd1);
    chk({tag, "_vld"}, 128'(out_valid_o), 128'd0);
    chk({tag, "_pc"}, 128'(out_pc_o), 128'd0);
    chk({tag, "_pay"}, out_payload_o, NOP);
    chk({tag, "_cnt"}, 128'(count_o), 128'd0);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc,
                          input int cnt);
    chk({tag, "_vld"}, 128'(out_valid_o), 128'd1);
    chk({tag, "_pc"}, 128'(out_pc_o), 128'(pc));
    chk({tag, "_pay"}, out_payload_o, pay(pc));
    chk({tag, "_cnt"}, 128'(count_o), 128'(cnt));
  endtask

  logic [31:0] fill_pc [4];
  logic [31:0] wrap_pc [4];

  initial begin
    checks   = 0;
    failures = 0;
    fill_pc  = '{32'h100, 32'h104, 32'h108, 32'h10C};
    wrap_pc  = '{32'h108, 32'h10C, 32'h110, 32'h114};
    rst      = 1'b0;
    flush_i  = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    #3;
    chk_idle("reset");
    step();
    rst = 1'b1;

    // fill to DEPTH with ID stalled
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, fill_pc[i], 1'b0);
      step();
      chk_head($sformatf("fill%0d", i), 32'h100, i + 1);
    end
    chk("full_rdy", 128'(in_ready_o), 128'd0);
    drive(1'b1, 32'h110, 1'b0);
    step();
    chk_head("fifth", 32'h100, 4);

    // pop two, push two across the wrap
    drive(1'b0, 32'h0, 1'b1);
    step();
    chk_head("pop1", 32'h104, 3);
    step();
    chk_head("pop2", 32'h108, 2);
    drive(1'b1, 32'h110, 1'b0);
    step();
    drive(1'b1, 32'h114, 1'b0);
    step();
    chk("wrap_cnt", 128'(count_o), 128'd4);
    drive(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk_head($sformatf("drain%0d", i), wrap_pc[i], 4 - i);
      step();
    end
    chk_idle("empty");

    // push into empty queue with ID ready, then steady push+pop
    drive(1'b1, 32'h200, 1'b1);
    step();
    chk_head("sim0", 32'h200, 1);
    drive(1'b1, 32'h204, 1'b1);
    step();
    chk_head("sim1", 32'h204, 1);
    drive(1'b1, 32'h208, 1'b1);
    step();
    chk_head("sim2", 32'h208, 1);
    drive(1'b0, 32'h0, 1'b1);
    step();
    chk_idle("sim_end");

    // flush at count 3 with a push pending
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i), 1'b0);
      step();
    end
    chk_head("pre_flush", 32'h300, 3);
    drive(1'b1, 32'h30C, 1'b1);
    flush_i = 1'b1;
    #1;
    chk("flush_vld", 128'(out_valid_o), 128'd0);
    chk("flush_pc", 128'(out_pc_o), 128'd0);
    step();
    flush_i = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    #1;
    chk_idle("post_flush");
    drive(1'b1, 32'h400, 1'b0);
    step();
    chk_head("after_flush", 32'h400, 1);
    drive(1'b0, 32'h0, 1'b1);
    step();
    chk_idle("flush_end");

    // reset-guard drop
    drive(1'b1, DRP, 1'b0);
    #1;
    chk("drop_rdy", 128'(in_ready_o), 128'd1);
    step();
    chk_idle("drop");
    drive(1'b1, 32'h8000_0000, 1'b0);
    #1;
    chk("boot_rdy", 128'(in_ready_o), 128'd1);
    step();
    chk_head("boot", 32'h8000_0000, 1);

    // async reset between edges
    drive(1'b1, 32'h8000_0004, 1'b0);
    step();
    chk_head("pre_rst", 32'h8000_0000, 2);
    drive(1'b0, 32'h0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk_idle("mid_rst");
    step();
    rst = 1'b1;
    drive(1'b1, 32'h500, 1'b0);
    step();
    chk_head("resume", 32'h500, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
